// File: rtl/dmem_mc.sv
// dmem_mc: multi-cycle, byte-addressable data memory with a request/ready
// handshake, programmable wait states and fault reporting.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 4)
//   WAIT_STATES  extra cycles per valid access (0..15)
//
// Ports:
//   Clock     rising-edge clock
//   Reset     synchronous, active-high
//   Read      load request (sampled in IDLE only)
//   Write     store request (sampled in IDLE only)
//   Size      00 byte, 01 half, 10 word, 11 reserved
//   Unsigned  1 = zero-extend loads, 0 = sign-extend loads
//   Addr      byte address
//   DataIn    right-aligned store data
//   DataOut   registered, extended load result
//   Ready     one-cycle completion pulse
//   Fault     qualifies Ready: the access was rejected
//   Busy      high whenever the controller is not IDLE
module dmem_mc #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Ready,
  output logic        Fault,
  output logic        Busy
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          commit, fault_set, fault_q;

  // Registered request, captured on the accepting edge.
  logic          r_read, r_write, r_uns;
  logic [1:0]    r_size;
  logic [31:0]   r_addr, r_din;

  logic [31:0]   mem [DEPTH];

  // In IDLE the request is evaluated straight from the inputs so that a
  // zero-wait access can complete on its accepting edge; afterwards the
  // captured copy is used and the inputs are ignored.
  logic          cur_read, cur_write, cur_uns;
  logic [1:0]    cur_size;
  logic [31:0]   cur_addr, cur_din;
  logic          req_in, cur_fault;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   old_word, store_word, load_val;

  assign req_in    = (state == IDLE) && (Read || Write);
  assign cur_read  = (state == IDLE) ? Read     : r_read;
  assign cur_write = (state == IDLE) ? Write    : r_write;
  assign cur_size  = (state == IDLE) ? Size     : r_size;
  assign cur_uns   = (state == IDLE) ? Unsigned : r_uns;
  assign cur_addr  = (state == IDLE) ? Addr     : r_addr;
  assign cur_din   = (state == IDLE) ? DataIn   : r_din;

  assign word_idx  = cur_addr[AW+1:2];
  assign lane      = cur_addr[1:0];
  assign old_word  = mem[word_idx];

  assign cur_fault = (cur_read && cur_write)
                  || (cur_size == 2'b11)
                  || (cur_size == 2'b01 && lane[0])
                  || (cur_size == 2'b10 && lane != 2'b00)
                  || (|cur_addr[31:AW+2]);

  // Store: replace only the addressed lanes of the current word.
  always_comb begin
    store_word = old_word;
    case (cur_size)
      2'b00:   store_word[{lane, 3'b000} +: 8]        = cur_din[7:0];
      2'b01:   store_word[{lane[1], 4'b0000} +: 16]   = cur_din[15:0];
      default: store_word                             = cur_din;
    endcase
  end

  // Load: extract the addressed lane and extend it.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b        = old_word[{lane, 3'b000} +: 8];
    h        = old_word[{lane[1], 4'b0000} +: 16];
    load_val = old_word;
    case (cur_size)
      2'b00:   load_val = {{24{~cur_uns & b[7]}}, b};
      2'b01:   load_val = {{16{~cur_uns & h[15]}}, h};
      default: load_val = old_word;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    fault_set = 1'b0;
    case (state)
      IDLE: begin
        if (req_in) begin
          if (cur_fault) begin
            state_nxt = DONE;
            fault_set = 1'b1;
          end else if (WS == 4'd0) begin
            state_nxt = DONE;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WS - 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      fault_q <= 1'b0;
      DataOut <= 32'd0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'd0;
      r_din   <= 32'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      fault_q <= fault_set;
      if (req_in) begin
        r_read  <= Read;
        r_write <= Write;
        r_uns   <= Unsigned;
        r_size  <= Size;
        r_addr  <= Addr;
        r_din   <= DataIn;
      end
      if (commit && cur_read)
        DataOut <= load_val;
    end
  end

  // NOTE: the array has no reset; its contents are undefined at power-up and
  // a reset only suppresses a store that would otherwise commit on this edge.
  always_ff @(posedge Clock) begin
    if (commit && cur_write && !Reset)
      mem[word_idx] <= store_word;
  end

  assign Ready = (state == DONE);
  assign Fault = fault_q;
  assign Busy  = (state != IDLE);

endmodule

// File: tb/tb_dmem_mc.sv
// Self-checking bench for dmem_mc. Two instances are exercised: one with
// two wait states (index 0) and one with zero wait states (index 1). A
// byte-level reference model predicts every completion; expectations are
// queued when an access is accepted and a negedge monitor pops and compares
// them whenever Ready is seen.
module tb_dmem_mc;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        rd  [2];
  logic        wr  [2];
  logic        uns [2];
  logic [1:0]  sz  [2];
  logic [31:0] ad  [2];
  logic [31:0] di  [2];
  logic [31:0] dout[2];
  logic        rdy [2];
  logic        flt [2];
  logic        bsy [2];

  dmem_mc #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut_ws2 (
    .Clock(clk), .Reset(rst[0]), .Read(rd[0]), .Write(wr[0]), .Size(sz[0]),
    .Unsigned(uns[0]), .Addr(ad[0]), .DataIn(di[0]), .DataOut(dout[0]),
    .Ready(rdy[0]), .Fault(flt[0]), .Busy(bsy[0]));

  dmem_mc #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut_ws0 (
    .Clock(clk), .Reset(rst[1]), .Read(rd[1]), .Write(wr[1]), .Size(sz[1]),
    .Unsigned(uns[1]), .Addr(ad[1]), .DataIn(di[1]), .DataOut(dout[1]),
    .Ready(rdy[1]), .Fault(flt[1]), .Busy(bsy[1]));

  typedef struct {
    logic        fault;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  mb [int];
  logic [31:0] last [2];
  int          prev_acc [2];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int key(input int d, input logic [31:0] a);
    return d * 4096 + int'(a);
  endfunction

  function automatic bit model_fault(input bit r, input bit w, input logic [1:0] s,
                                     input logic [31:0] a);
    if (r && w) return 1'b1;
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1 && (a % 2) != 0) return 1'b1;
    if (s == 2'd2 && (a % 4) != 0) return 1'b1;
    if (a >= 32'(4 * DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_store(input int d, input logic [1:0] s, input logic [31:0] a,
                             input logic [31:0] v);
    int n;
    logic [31:0] t;
    n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    t = v;
    for (int i = 0; i < n; i++) begin
      mb[key(d, a + 32'(i))] = t[7:0];
      t = t >> 8;
    end
  endtask

  function automatic logic [31:0] model_load(input int d, input logic [1:0] s,
                                             input bit u, input logic [31:0] a);
    longint v;
    int n;
    n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(mb[key(d, a + 32'(i))]);
    if (n == 1 && !u && v >= 128)   v = v - 256;
    if (n == 2 && !u && v >= 32768) v = v - 65536;
    return v[31:0];
  endfunction

  task automatic mon(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      check($sformatf("unexpected_ready[%0d]", d), 32'd1, 32'd0);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check($sformatf("fault[%0d]", d), 32'(flt[d]), 32'(e.fault));
    check($sformatf("dataout[%0d]", d), dout[d], e.data);
    check($sformatf("latency[%0d]", d), cyc, e.due);
    check($sformatf("busy_at_ready[%0d]", d), 32'(bsy[d]), 32'd1);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (rdy[d] === 1'b1) mon(d);
  end

  task automatic clear_in(input int d);
    rd[d] = 1'b0; wr[d] = 1'b0; sz[d] = 2'd0; uns[d] = 1'b0;
    ad[d] = 32'd0; di[d] = 32'd0;
  endtask

  // Called just after a negedge; returns just after a negedge in IDLE.
  task automatic access(input int d, input bit r, input bit w, input logic [1:0] s,
                        input bit u, input logic [31:0] a, input logic [31:0] v,
                        input bit junk);
    int   t;
    bit   f;
    exp_t e;
    t = 0;
    while (bsy[d] !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("idle_timeout", 32'd1, 32'd0);
    f = model_fault(r, w, s, a);
    if (!f && r) last[d] = model_load(d, s, u, a);
    if (!f && w) model_store(d, s, a, v);
    e.fault = f;
    e.data  = last[d];
    rd[d] = r; wr[d] = w; sz[d] = s; uns[d] = u; ad[d] = a; di[d] = v;
    @(posedge clk); #1;
    e.due = cyc + (f ? 0 : ws_of(d));
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    if (d == 1 && prev_acc[1] >= 0) check("accept_spacing", 32'(cyc - prev_acc[1]), 32'd2);
    prev_acc[d] = cyc;
    clear_in(d);
    t = 0;
    @(negedge clk);
    while (bsy[d] !== 1'b0 && t < 50) begin
      if (junk) begin
        rd[d] = 1'($urandom); wr[d] = 1'($urandom);
        sz[d] = 2'($urandom); ad[d] = 32'($urandom_range(0, 255));
        di[d] = $urandom;
      end
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("done_timeout", 32'd1, 32'd0);
    clear_in(d);
  endtask

  task automatic rand_access(input int d);
    bit r, w;
    logic [1:0] s;
    logic [31:0] a;
    r = 1'($urandom_range(0, 1));
    w = !r;
    if ($urandom_range(0, 15) == 0) begin r = 1'b1; w = 1'b1; end
    s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    a = ($urandom_range(0, 15) == 0) ? 32'(4 * DEPTH + $urandom_range(0, 7))
                                     : 32'($urandom_range(0, 127));
    access(d, r, w, s, 1'($urandom), a, $urandom, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; clear_in(d); last[d] = 32'd0; prev_acc[d] = -1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_dataout", dout[d], 32'd0);
      check("reset_ready",   32'(rdy[d]), 32'd0);
      check("reset_fault",   32'(flt[d]), 32'd0);
      check("reset_busy",    32'(bsy[d]), 32'd0);
      rst[d] = 1'b0;
    end
    @(negedge clk);

    // Word store/load, two wait states.
    access(0, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
    access(0, 1, 0, 2'd2, 0, 32'h10, 32'h0, 0);

    // Byte and half lanes.
    access(0, 0, 1, 2'd2, 0, 32'h20, 32'h11223344, 0);
    access(0, 0, 1, 2'd0, 0, 32'h21, 32'h000000AA, 0);
    access(0, 0, 1, 2'd1, 0, 32'h22, 32'h00008001, 0);
    access(0, 1, 0, 2'd2, 0, 32'h20, 32'h0, 0);
    access(0, 1, 0, 2'd0, 0, 32'h21, 32'h0, 0);
    access(0, 1, 0, 2'd0, 1, 32'h21, 32'h0, 0);
    access(0, 1, 0, 2'd1, 0, 32'h22, 32'h0, 0);
    access(0, 1, 0, 2'd1, 1, 32'h22, 32'h0, 0);

    // Faults: DataOut must hold the last load and memory stays intact.
    access(0, 1, 0, 2'd2, 0, 32'h22, 32'h0, 0);
    access(0, 0, 1, 2'd1, 0, 32'h23, 32'hFFFF, 0);
    access(0, 0, 1, 2'd2, 0, 32'(4 * DEPTH), 32'hCAFEF00D, 0);
    access(0, 1, 0, 2'd3, 0, 32'h20, 32'h0, 0);
    access(0, 1, 1, 2'd2, 0, 32'h20, 32'h55555555, 0);
    access(0, 1, 0, 2'd2, 0, 32'h20, 32'h0, 0);
    access(0, 1, 0, 2'd2, 0, 32'h00, 32'h0, 0 ? 1'b0 : 1'b0) ;

    // Inputs toggled while busy are ignored.
    access(0, 1, 0, 2'd2, 0, 32'h10, 32'h0, 1);
    access(0, 0, 1, 2'd0, 0, 32'h13, 32'h0000007E, 1);
    access(0, 1, 0, 2'd2, 0, 32'h10, 32'h0, 0);

    // Reset during WAIT aborts an uncommitted store.
    access(0, 0, 1, 2'd2, 0, 32'h40, 32'h0, 0);
    access(0, 1, 0, 2'd2, 0, 32'h10, 32'h0, 0);
    wr[0] = 1'b1; sz[0] = 2'd2; ad[0] = 32'h40; di[0] = 32'h12345678;
    @(posedge clk); #1;
    clear_in(0);
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_ready",   32'(rdy[0]), 32'd0);
    check("abort_fault",   32'(flt[0]), 32'd0);
    check("abort_busy",    32'(bsy[0]), 32'd0);
    check("abort_dataout", dout[0], 32'd0);
    last[0] = 32'd0;
    @(negedge clk);
    // Reset on the same edge as a request drops the request.
    rd[0] = 1'b1; sz[0] = 2'd2; ad[0] = 32'h10;
    @(posedge clk); #1;
    clear_in(0);
    rst[0] = 1'b0;
    @(negedge clk);
    check("reset_wins_busy", 32'(bsy[0]), 32'd0);
    access(0, 1, 0, 2'd2, 0, 32'h40, 32'h0, 0);

    // Randomized traffic on the two-wait-state instance.
    for (int i = 0; i < 32; i++) access(0, 0, 1, 2'd2, 0, 32'(4 * i), $urandom, 0);
    for (int i = 0; i < 60; i++) rand_access(0);

    // Zero wait states, back-to-back accesses every two cycles.
    access(1, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
    access(1, 1, 0, 2'd2, 0, 32'h10, 32'h0, 0);
    access(1, 0, 1, 2'd0, 0, 32'h12, 32'h000000F0, 0);
    access(1, 1, 0, 2'd0, 0, 32'h12, 32'h0, 0);
    access(1, 1, 0, 2'd1, 0, 32'h11, 32'h0, 0);
    access(1, 1, 0, 2'd1, 1, 32'h12, 32'h0, 0);
    for (int i = 0; i < 32; i++) access(1, 0, 1, 2'd2, 0, 32'(4 * i), $urandom, 0);
    for (int i = 0; i < 60; i++) rand_access(1);

    repeat (10) @(negedge clk);
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
